// File: rtl/fetch_sched.sv
// fetch_sched: fetch-stage redirect scheduler.
// Arbitrates jump, branch and exception redirects for the fetch PC. A redirect
// that arrives while fetch is frozen is parked in a pending register. The
// scheduler supervises the flush window that follows an exception.
module fetch_sched #(
    parameter int unsigned EXC_FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_req,
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic [31:0] exc_target,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] next_pc,
    output logic        flushD,
    output logic        flushE,
    output logic [15:0] redirect_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Numeric order of the kinds is the redirect priority.
    typedef enum logic [1:0] {
        K_NONE = 2'd0,
        K_JUMP = 2'd1,
        K_BR   = 2'd2,
        K_EXC  = 2'd3
    } kind_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(EXC_FLUSH_CYCLES);

    state_t      state_q, state_nxt;
    logic [3:0]  fcnt_q, fcnt_nxt;
    kind_t       pend_kind_q, pend_kind_nxt;
    logic [31:0] pend_target_q, pend_target_nxt;

    kind_t       win_kind;
    logic [31:0] win_target;
    kind_t       issue_kind;
    logic [31:0] issue_target;

    assign stall = stall_req;

    // Fixed-priority pick of this cycle's incoming redirect.
    always_comb begin
        win_kind   = K_NONE;
        win_target = 32'h0;
        if (exc_req) begin
            win_kind   = K_EXC;
            win_target = exc_target;
        end else if (br_req) begin
            win_kind   = K_BR;
            win_target = br_target;
        end else if (jump_req) begin
            win_kind   = K_JUMP;
            win_target = jump_target;
        end
    end

    // Next-state, pending/flush-counter updates and redirect outputs.
    always_comb begin
        // NOTE: every output of this block is given a default first so no path can infer a latch.
        state_nxt       = state_q;
        fcnt_nxt        = fcnt_q;
        pend_kind_nxt   = pend_kind_q;
        pend_target_nxt = pend_target_q;
        issue_kind      = K_NONE;
        issue_target    = 32'h0;
        pc_src          = 1'b0;
        next_pc         = 32'h0;
        flushD          = 1'b0;
        flushE          = 1'b0;

        case (state_q)
            S_RUN: begin
                if (win_kind != K_NONE) begin
                    if (!stall_req) begin
                        issue_kind   = win_kind;
                        issue_target = win_target;
                    end else begin
                        pend_kind_nxt   = win_kind;
                        pend_target_nxt = win_target;
                        state_nxt       = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (stall_req) begin
                    // Only a strictly more urgent request displaces the parked one.
                    if (win_kind > pend_kind_q) begin
                        pend_kind_nxt   = win_kind;
                        pend_target_nxt = win_target;
                    end
                end else begin
                    if (win_kind > pend_kind_q) begin
                        issue_kind   = win_kind;
                        issue_target = win_target;
                    end else begin
                        issue_kind   = pend_kind_q;
                        issue_target = pend_target_q;
                    end
                    pend_kind_nxt   = K_NONE;
                    pend_target_nxt = 32'h0;
                    state_nxt       = S_RUN;
                end
            end

            S_FLUSH: begin
                flushD = 1'b1;
                flushE = 1'b1;
                // Branches and jumps come from wrong-path instructions here; drop them.
                if (exc_req) begin
                    if (!stall_req) begin
                        issue_kind   = K_EXC;
                        issue_target = exc_target;
                    end else begin
                        pend_kind_nxt   = K_EXC;
                        pend_target_nxt = exc_target;
                        fcnt_nxt        = 4'd0;
                        state_nxt       = S_HOLD;
                    end
                end else if (fcnt_q <= 4'd1) begin
                    fcnt_nxt  = 4'd0;
                    state_nxt = S_RUN;
                end else begin
                    fcnt_nxt = fcnt_q - 4'd1;
                end
            end

            default: begin
                state_nxt       = S_RUN;
                fcnt_nxt        = 4'd0;
                pend_kind_nxt   = K_NONE;
                pend_target_nxt = 32'h0;
            end
        endcase

        // Common issue path shared by RUN, HOLD and FLUSH.
        if (issue_kind != K_NONE) begin
            pc_src  = 1'b1;
            next_pc = issue_target;
            flushD  = 1'b1;
            flushE  = flushE | (issue_kind == K_BR) | (issue_kind == K_EXC);
            if (issue_kind == K_EXC) begin
                state_nxt = S_FLUSH;
                fcnt_nxt  = FLUSH_LOAD;
            end else begin
                state_nxt = S_RUN;
                fcnt_nxt  = 4'd0;
            end
        end

        // NOTE: outputs are combinational from inputs, so they are masked while reset is held.
        if (!reset) begin
            pc_src  = 1'b0;
            next_pc = 32'h0;
            flushD  = 1'b0;
            flushE  = 1'b0;
        end
    end

    // State, pending redirect, flush counter and redirect counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_RUN;
            fcnt_q        <= 4'd0;
            pend_kind_q   <= K_NONE;
            pend_target_q <= 32'h0;
            redirect_cnt  <= 16'h0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_nxt;
            fcnt_q        <= fcnt_nxt;
            pend_kind_q   <= pend_kind_nxt;
            pend_target_q <= pend_target_nxt;
            redirect_cnt  <= redirect_cnt + 16'(pc_src);
        end
    end

endmodule

// File: tb/tb_fetch_sched.sv
// tb_fetch_sched: directed table-driven bench for fetch_sched.
module tb_fetch_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_req, jump_req, br_req, exc_req;
    logic [31:0] jump_target, br_target, exc_target;
    logic        stall, pc_src, flushD, flushE;
    logic [31:0] next_pc;
    logic [15:0] redirect_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    fetch_sched #(.EXC_FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_req    (stall_req),
        .jump_req     (jump_req),
        .jump_target  (jump_target),
        .br_req       (br_req),
        .br_target    (br_target),
        .exc_req      (exc_req),
        .exc_target   (exc_target),
        .stall        (stall),
        .pc_src       (pc_src),
        .next_pc      (next_pc),
        .flushD       (flushD),
        .flushE       (flushE),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sr;
        logic        jr;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        er;
        logic [31:0] et;
        logic        e_pc;
        logic [31:0] e_np;
        logic        e_fd;
        logic        e_fe;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic sr, input logic jr, input logic [31:0] jt,
                                input logic br, input logic [31:0] bt,
                                input logic er, input logic [31:0] et,
                                input logic e_pc, input logic [31:0] e_np,
                                input logic e_fd, input logic e_fe, input logic [15:0] e_cnt);
        vec_t v;
        v.sr = sr; v.jr = jr; v.jt = jt; v.br = br; v.bt = bt; v.er = er; v.et = et;
        v.e_pc = e_pc; v.e_np = e_np; v.e_fd = e_fd; v.e_fe = e_fe; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sr, input logic jr, input logic [31:0] jt,
                         input logic br, input logic [31:0] bt,
                         input logic er, input logic [31:0] et);
        stall_req = sr; jump_req = jr; jump_target = jt;
        br_req = br; br_target = bt; exc_req = er; exc_target = et;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic check_outs(input string tag, input logic e_stall, input logic e_pc,
                              input logic [31:0] e_np, input logic e_fd, input logic e_fe,
                              input logic [15:0] e_cnt);
        check({tag, ".stall"},   32'(stall),        32'(e_stall));
        check({tag, ".pc_src"},  32'(pc_src),       32'(e_pc));
        check({tag, ".next_pc"}, next_pc,           e_np);
        check({tag, ".flushD"},  32'(flushD),       32'(e_fd));
        check({tag, ".flushE"},  32'(flushE),       32'(e_fe));
        check({tag, ".cnt"},     32'(redirect_cnt), 32'(e_cnt));
    endtask

    initial begin
        // sr jr jt          br bt          er et           | pc np           fd fe cnt
        vecs[0]  = mk(0,0,32'h0,   0,32'h0,   0,32'h0,    0,32'h0,    0,0,16'd0);
        vecs[1]  = mk(0,1,32'h3100,1,32'h3040,0,32'h0,    1,32'h3040, 1,1,16'd0);
        vecs[2]  = mk(1,0,32'h0,   0,32'h0,   0,32'h0,    0,32'h0,    0,0,16'd1);
        vecs[3]  = mk(1,1,32'h3100,0,32'h0,   0,32'h0,    0,32'h0,    0,0,16'd1);
        vecs[4]  = mk(1,1,32'h3100,0,32'h0,   0,32'h0,    0,32'h0,    0,0,16'd1);
        vecs[5]  = mk(1,1,32'h3100,0,32'h0,   0,32'h0,    0,32'h0,    0,0,16'd1);
        vecs[6]  = mk(0,1,32'h3100,0,32'h0,   0,32'h0,    1,32'h3100, 1,0,16'd1);
        vecs[7]  = mk(0,0,32'h0,   0,32'h0,   0,32'h0,    0,32'h0,    0,0,16'd2);
        vecs[8]  = mk(1,1,32'h3100,0,32'h0,   0,32'h0,    0,32'h0,    0,0,16'd2);
        vecs[9]  = mk(1,0,32'h0,   1,32'h3200,0,32'h0,    0,32'h0,    0,0,16'd2);
        vecs[10] = mk(0,0,32'h0,   0,32'h0,   0,32'h0,    1,32'h3200, 1,1,16'd2);
        vecs[11] = mk(0,0,32'h0,   0,32'h0,   0,32'h0,    0,32'h0,    0,0,16'd3);
        vecs[12] = mk(0,0,32'h0,   1,32'h3040,1,32'h4180, 1,32'h4180, 1,1,16'd3);
        vecs[13] = mk(0,0,32'h0,   1,32'h3040,0,32'h0,    0,32'h0,    1,1,16'd4);
        vecs[14] = mk(0,1,32'h3100,0,32'h0,   0,32'h0,    0,32'h0,    1,1,16'd4);
        vecs[15] = mk(0,0,32'h0,   0,32'h0,   0,32'h0,    0,32'h0,    0,0,16'd4);
        vecs[16] = mk(1,0,32'h0,   1,32'h3200,0,32'h0,    0,32'h0,    0,0,16'd4);
        vecs[17] = mk(1,1,32'h3100,0,32'h0,   0,32'h0,    0,32'h0,    0,0,16'd4);
        vecs[18] = mk(0,1,32'h3100,0,32'h0,   0,32'h0,    1,32'h3200, 1,1,16'd4);
        vecs[19] = mk(1,1,32'h3100,0,32'h0,   0,32'h0,    0,32'h0,    0,0,16'd5);
        vecs[20] = mk(0,0,32'h0,   0,32'h0,   1,32'h4180, 1,32'h4180, 1,1,16'd5);
        vecs[21] = mk(0,0,32'h0,   0,32'h0,   1,32'h4000, 1,32'h4000, 1,1,16'd6);
        vecs[22] = mk(0,0,32'h0,   0,32'h0,   0,32'h0,    0,32'h0,    1,1,16'd7);
        vecs[23] = mk(0,0,32'h0,   0,32'h0,   0,32'h0,    0,32'h0,    1,1,16'd7);
        vecs[24] = mk(0,0,32'h0,   0,32'h0,   0,32'h0,    0,32'h0,    0,0,16'd7);
        vecs[25] = mk(0,0,32'h0,   0,32'h0,   1,32'h4180, 1,32'h4180, 1,1,16'd7);
        vecs[26] = mk(1,0,32'h0,   0,32'h0,   1,32'h4200, 0,32'h0,    1,1,16'd8);
        vecs[27] = mk(1,0,32'h0,   1,32'h3040,0,32'h0,    0,32'h0,    0,0,16'd8);
        vecs[28] = mk(0,0,32'h0,   0,32'h0,   0,32'h0,    1,32'h4200, 1,1,16'd8);
        vecs[29] = mk(0,0,32'h0,   0,32'h0,   0,32'h0,    0,32'h0,    1,1,16'd9);
        vecs[30] = mk(0,0,32'h0,   0,32'h0,   0,32'h0,    0,32'h0,    1,1,16'd9);
        vecs[31] = mk(0,0,32'h0,   0,32'h0,   0,32'h0,    0,32'h0,    0,0,16'd9);

        // Reset state: requests present while reset is held must not redirect.
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h4180);
        #2;
        check_outs("reset_hold", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        idle();
        @(negedge clk);
        reset = 1'b1;

        // Table of cycle-by-cycle vectors.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].sr, vecs[i].jr, vecs[i].jt, vecs[i].br, vecs[i].bt,
                  vecs[i].er, vecs[i].et);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].sr, vecs[i].e_pc, vecs[i].e_np,
                       vecs[i].e_fd, vecs[i].e_fe, vecs[i].e_cnt);
        end

        // Counter wrap: clear, then 65536 back-to-back jump redirects.
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        check("wrap.cleared", 32'(redirect_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 32'h5000, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        @(negedge clk);
        #1;
        check("wrap.ffff", 32'(redirect_cnt), 32'h0000FFFF);
        check("wrap.pc_src", 32'(pc_src), 32'd1);
        @(negedge clk);
        idle();
        #1;
        check("wrap.zero", 32'(redirect_cnt), 32'd0);

        // Reset asserted while a jump is parked in HOLD.
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h3100, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("hold_rst.park", 32'(pc_src), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h4180);
        #1;
        check_outs("hold_rst.during", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        idle();
        #1;
        check_outs("hold_rst.after", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        #1;
        check_outs("hold_rst.after2", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);

        // Reset asserted in the middle of an exception flush window.
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h4180);
        #1;
        check("flush_rst.issue", next_pc, 32'h4180);
        @(negedge clk);
        idle();
        #1;
        check("flush_rst.flushing", 32'(flushD), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outs("flush_rst.after", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sched.md
FETCH_SCHED -- requirements
Module: fetch_sched

Interface
REQ-001 SHALL have parameter EXC_FLUSH_CYCLES, default 2, range 1..15: number of flush cycles after an exception redirect.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port stall_req, input, 1: hazard-unit request to freeze fetch.
REQ-005 SHALL have ports jump_req, input, 1, and jump_target, input, 32: ID-stage jump redirect.
REQ-006 SHALL have ports br_req, input, 1, and br_target, input, 32: EX-stage taken-branch redirect.
REQ-007 SHALL have ports exc_req, input, 1, and exc_target, input, 32: exception-vector redirect.
REQ-008 SHALL have port stall, output, 1: freeze to fetch-stage PC.
REQ-009 SHALL have ports pc_src, output, 1, and next_pc, output, 32: redirect select and target to fetch-stage PC.
REQ-010 SHALL have ports flushD, output, 1, and flushE, output, 1: clear IF/ID and ID/EX pipeline registers.
REQ-011 SHALL have port redirect_cnt, output, 16: count of redirects issued.

Function
REQ-012 SHALL implement states RUN, HOLD, FLUSH, with 4-bit flush counter fcnt.
REQ-013 SHALL resolve redirect priority: exc_req > br_req > jump_req; one winner per cycle.
REQ-014 SHALL drive stall = stall_req combinationally in every state.
REQ-015 RUN, winner present, stall_req=0: pc_src=1, next_pc=winner target in the same cycle; flushD=1; flushE=1 if winner is br or exc.
REQ-016 RUN, winner present, stall_req=1: pc_src=0; latch winner target and kind into pending register; next state HOLD.
REQ-017 HOLD, stall_req=1: new request strictly higher priority than pending replaces pending; equal or lower is ignored; pc_src=0.
REQ-018 HOLD, stall_req=0: issue pending per REQ-015 unless a same-cycle request of strictly higher priority exists, which is issued instead; pending cleared.
REQ-019 After issue from RUN or HOLD: next state FLUSH with fcnt=EXC_FLUSH_CYCLES if issued kind is exc; otherwise RUN.
REQ-020 FLUSH: flushD=1 and flushE=1 each cycle; fcnt decrements by 1 per cycle; state becomes RUN on the cycle fcnt reaches 0.
REQ-021 FLUSH: br_req and jump_req ignored and not latched; exc_req with stall_req=0 is issued immediately and fcnt reloads to EXC_FLUSH_CYCLES.
REQ-022 FLUSH: exc_req with stall_req=1 is latched as pending exc; next state HOLD.
REQ-023 When pc_src=0, next_pc SHALL be 32'h0.
REQ-024 redirect_cnt SHALL increment by 1 on every cycle with pc_src=1 and wrap from 16'hFFFF to 0.
REQ-025 pc_src SHALL never be 1 while stall_req=1.

Reset
REQ-026 reset=0 SHALL asynchronously force state RUN, fcnt=0, pending cleared, redirect_cnt=0.
REQ-027 During reset, pc_src=0, next_pc=0, flushD=0, flushE=0; stall follows stall_req.
REQ-028 Reset asserted mid-HOLD or mid-FLUSH SHALL discard the pending redirect and flush count with no redirect issued after release.
REQ-029 First posedge after reset release SHALL evaluate in RUN.

Verification
REQ-030 RUN, br_req=1, br_target=32'h3040, jump_req=1, stall_req=0 -> same cycle pc_src=1, next_pc=32'h3040, flushD=1, flushE=1, redirect_cnt 0->1.
REQ-031 jump_req=1, jump_target=32'h3100 with stall_req=1 for 3 cycles, then 0 -> pc_src=0 for 3 cycles; on 4th cycle pc_src=1, next_pc=32'h3100, flushE=0.
REQ-032 HOLD with pending jump; br_req=1, br_target=32'h3200 while stalled -> on release next_pc=32'h3200; jump discarded; redirect_cnt +1 only.
REQ-033 exc_req=1, exc_target=32'h4180, EXC_FLUSH_CYCLES=2 -> pc_src=1 that cycle; flushD=flushE=1 for the next 2 cycles; br_req during them ignored.
REQ-034 Drive 65536 redirects -> redirect_cnt wraps to 0; assert reset in HOLD -> pending lost, pc_src=0 after release.
